// File: rtl/alu_n.sv
// rtl/alu_n.sv - registered N-bit ALU with valid/ready handshake, Z/N/C/V flags and multi-cycle shifts
// Optional shift-add multiply on opcode 12 when ALU_N_MUL_EN is defined.
module alu_n #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_NOT = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_TRF = 4'd6;
    localparam logic [3:0] OP_TST = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBC = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] work, work_nx;
    logic [SHW:0]     cnt;
    logic             c_work, c_work_nx;
    logic [SHW-1:0]   k;
    logic [WIDTH-1:0] r_val, f_val;
    logic             c_val, v_val, e_val, long_op, cin;
    logic [WIDTH:0]   add_ext, sub_ext;
`ifdef ALU_N_MUL_EN
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    logic [WIDTH-1:0] acc, acc_nx, mcand;
    logic [WIDTH:0]   mul_sum;
`endif

    assign k         = b[SHW-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle datapath, evaluated from the live inputs in IDLE
    always_comb begin
        cin     = (op == OP_ADC || op == OP_SBC) ? flag_c : carry_in;
        add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        r_val   = result;
        c_val   = flag_c;
        v_val   = 1'b0;
        e_val   = 1'b0;
        long_op = 1'b0;
        case (op)
            OP_AND: r_val = a & b;
            OP_NOT: r_val = ~a;
            OP_OR:  r_val = a | b;
            OP_XOR: r_val = a ^ b;
            OP_ADD, OP_ADC: begin
                r_val = add_ext[WIDTH-1:0];
                c_val = add_ext[WIDTH];
                v_val = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                r_val = sub_ext[WIDTH-1:0];
                c_val = sub_ext[WIDTH];
                v_val = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_TRF: r_val = a;
            OP_TST: r_val = result;
            OP_SHL, OP_SHR: begin
                r_val   = a;
                long_op = (k != '0);
            end
`ifdef ALU_N_MUL_EN
            OP_MUL: long_op = 1'b1;
`endif
            default: begin
                r_val = '0;
                e_val = 1'b1;
            end
        endcase
        f_val = (op == OP_TST) ? (a & b) : r_val;
    end

    // One iteration of the multi-cycle operation held in op_q
    always_comb begin
        work_nx   = work;
        c_work_nx = c_work;
`ifdef ALU_N_MUL_EN
        acc_nx  = acc;
        mul_sum = '0;
`endif
        case (op_q)
            OP_SHL: begin
                work_nx   = {work[WIDTH-2:0], 1'b0};
                c_work_nx = work[WIDTH-1];
            end
            OP_SHR: begin
                work_nx   = {1'b0, work[WIDTH-1:1]};
                c_work_nx = work[0];
            end
`ifdef ALU_N_MUL_EN
            OP_MUL: begin
                // {acc, work} is the product register; multiplier bits leave work at the bottom
                mul_sum   = {1'b0, acc} + (work[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
                acc_nx    = mul_sum[WIDTH:1];
                work_nx   = {mul_sum[0], work[WIDTH-1:1]};
                c_work_nx = (mul_sum[WIDTH:1] != '0);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = long_op ? BUSY : DONE;
            BUSY:    if (cnt == CNT_ONE) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
            op_q   <= '0;
            work   <= '0;
            cnt    <= '0;
            c_work <= 1'b0;
`ifdef ALU_N_MUL_EN
            acc    <= '0;
            mcand  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op;
                    work   <= a;
                    cnt    <= {1'b0, k};
                    c_work <= flag_c;
`ifdef ALU_N_MUL_EN
                    acc    <= '0;
                    mcand  <= a;
                    if (op == OP_MUL) begin
                        work <= b;
                        cnt  <= CNT_MUL;
                    end
`endif
                    if (!long_op) begin
                        result <= r_val;
                        flag_z <= (f_val == '0);
                        flag_n <= f_val[WIDTH-1];
                        flag_c <= c_val;
                        flag_v <= v_val;
                        err    <= e_val;
                    end
                end
                BUSY: begin
                    work   <= work_nx;
                    c_work <= c_work_nx;
                    cnt    <= cnt - CNT_ONE;
`ifdef ALU_N_MUL_EN
                    acc    <= acc_nx;
`endif
                    if (cnt == CNT_ONE) begin
                        result <= work_nx;
                        flag_z <= (work_nx == '0);
                        flag_n <= work_nx[WIDTH-1];
                        flag_c <= c_work_nx;
                        flag_v <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_n.sv
// tb/tb_alu_n.sv - self-checking bench for alu_n: directed cases then random ops against an arithmetic model
module tb_alu_n;
    localparam int     W = 8;
    localparam longint M = longint'(1) << W;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, carry_in, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, result;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_res;
    logic         m_z, m_n, m_c, m_v, m_err;
    int           m_lat;

    always #5 clk = ~clk;

    alu_n #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: plain integer arithmetic on the opcode table; m_c and m_res persist across ops
    task automatic ref_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        longint ua, ub, sa, sb, full, sv, val, c_in;
        int     k;
        ua = longint'(x);
        ub = longint'(y);
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        k  = int'(y) % W;
        m_v = 1'b0;
        m_err = 1'b0;
        m_lat = 1;
        case (o)
            4'd0: m_res = x & y;
            4'd1: m_res = ~x;
            4'd2: m_res = x | y;
            4'd3: m_res = x ^ y;
            4'd4, 4'd8: begin
                c_in  = (o == 4'd4) ? longint'(ci) : longint'(m_c);
                full  = ua + ub + c_in;
                m_res = W'(full % M);
                m_c   = (full >= M);
                sv    = sa + sb + c_in;
                m_v   = (sv >= M/2) || (sv < -(M/2));
            end
            4'd5, 4'd9: begin
                c_in  = (o == 4'd5) ? longint'(ci) : longint'(m_c);
                full  = ua - ub - c_in;
                m_res = W'((full + M) % M);
                m_c   = (ua < ub + c_in);
                sv    = sa - sb - c_in;
                m_v   = (sv >= M/2) || (sv < -(M/2));
            end
            4'd6: m_res = x;
            4'd7: ;
            4'd10: begin
                m_res = W'((ua << k) % M);
                if (k != 0) m_c = ((ua >> (W - k)) & 1) != 0;
                m_lat = 1 + k;
            end
            4'd11: begin
                m_res = W'(ua >> k);
                if (k != 0) m_c = ((ua >> (k - 1)) & 1) != 0;
                m_lat = 1 + k;
            end
`ifdef ALU_N_MUL_EN
            4'd12: begin
                full  = ua * ub;
                m_res = W'(full % M);
                m_c   = (full / M) != 0;
                m_lat = 1 + W;
            end
`endif
            default: begin
                m_res = '0;
                m_err = 1'b1;
            end
        endcase
        val = (o == 4'd7) ? (ua & ub) : longint'(m_res);
        m_z = (val == 0);
        m_n = (val >= M/2);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int stall);
        int lat;
        ref_op(o, x, y, ci);
        chk("in_ready_idle", in_ready, 1'b1);
        op = o; a = x; b = y; carry_in = ci; in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            if (lat == 0) begin
                in_valid = 1'b0;
                op = 4'($urandom); a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
            end
            lat++;
        end while (!out_valid && lat < 100);
        chk("latency", lat, m_lat);
        chk("in_ready_done", in_ready, 1'b0);
        repeat (stall) begin @(posedge clk); #1; end
        chk("result", result, m_res);
        chk("flag_z", flag_z, m_z);
        chk("flag_n", flag_n, m_n);
        chk("flag_c", flag_c, m_c);
        chk("flag_v", flag_v, m_v);
        chk("err", err, m_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; carry_in = 1'b0;
        m_res = '0; m_c = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b0);

        run_op(4'd4, 8'hFF, 8'h01, 1'b0, 0);
        run_op(4'd8, 8'h00, 8'h00, 1'b0, 0);
        run_op(4'd5, 8'h80, 8'h01, 1'b0, 1);
        run_op(4'd5, 8'h00, 8'h01, 1'b0, 0);
        run_op(4'd11, 8'h81, 8'h00, 1'b0, 0);
        run_op(4'd10, 8'h81, 8'h03, 1'b0, 0);
        run_op(4'd11, 8'h81, 8'h07, 1'b0, 0);
        run_op(4'd12, 8'h10, 8'h10, 1'b0, 0);
        run_op(4'd14, 8'h3C, 8'h11, 1'b1, 0);

        // Backpressure: result held, new request ignored until DONE is drained
        ref_op(4'd3, 8'h5A, 8'h0F, 1'b0);
        op = 4'd3; a = 8'h5A; b = 8'h0F; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd4; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_result", result, m_res);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_consumed", out_valid, 1'b0);
        chk("bp_idle", in_ready, 1'b1);
        run_op(4'd4, 8'h11, 8'h22, 1'b0, 0);

        // Reset during a long shift
        op = 4'd10; a = 8'hA5; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_ready", in_ready, 1'b0);
        chk("busy_out_valid", out_valid, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_result", result, '0);
        chk("abort_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b0);
        m_res = '0; m_c = 1'b0;
        run_op(4'd7, 8'hF0, 8'h0F, 1'b0, 0);

        for (int i = 0; i < 80; i++)
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
